exunit_ldst: RTL and testbench
==============================

// Module: exunit_ldst
// PURPOSE
//  Load/store execution unit: consumer end of the load/store reservation-station entries.
//  - Accepts one issued op per handshake and forms address = rs1 + imm.
//  - Performs the memory access over a req/ack interface.
//  - Broadcasts load results on the exfin_ld forwarding bus that RS entries snoop.
//  - Reports store completion on a separate pulse with no data.
// PARAMETERS
//  DATA_W   32  operand/result width (RV32)
//  TAG_W    6   rename-register (RRF) tag width
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous reset, active-high
//  o_ready          out  1       unit idle; may accept issue this cycle
//  i_issue_vld      in   1       RS presents a ready op (RS asserts rd_en on accept)
//  i_rs1_srcopr     in   DATA_W  base address operand
//  i_rs2_srcopr     in   DATA_W  store data
//  i_imm            in   DATA_W  sign-extended offset
//  i_is_st          in   1       1=store, 0=load
//  i_size           in   2       0=byte 1=half 2=word (3 treated as word)
//  i_unsigned       in   1       load zero-extends when 1
//  i_rrftag         in   TAG_W   destination tag
//  i_flush          in   1       branch-mispredict kill of in-flight op
//  o_mem_req        out  1       memory request, held until ack
//  o_mem_we         out  1       write request
//  o_mem_addr       out  DATA_W  word-aligned address ({addr[31:2],2'b00})
//  o_mem_be         out  4       byte enables
//  o_mem_wdata      out  DATA_W  write data, lane-shifted
//  i_mem_ack        in   1       request accepted/completed this cycle
//  i_mem_rdata      in   DATA_W  read word, valid with ack on loads
//  o_exfin_ld       out  1       one-cycle load-finish broadcast
//  o_ex_ld_rrftag   out  TAG_W   tag of finished load
//  o_exfin_ld_res   out  DATA_W  extended load result
//  o_exfin_st       out  1       one-cycle store-finish pulse
//  o_ex_st_rrftag   out  TAG_W   tag of finished store
// BEHAVIOUR
//  - Reset values: state=IDLE; o_ready=1; every other output 0.
//  - Issue handshake: accept when o_ready && i_issue_vld.
//    Capture all issue fields and addr=rs1+imm (mod 2^32); go to REQ.
//    o_ready is combinational (state==IDLE); it is 0 in every other state.
//  - REQ: o_mem_req=1; addr/we/be/wdata are stable from registers.
//    On i_mem_ack (may arrive in the first REQ cycle):
//    - load: latch rdata; go to FIN.
//    - store: go to FIN.
//  - FIN: exactly one cycle.
//    - Load: o_exfin_ld=1, with tag and result.
//    - Store: o_exfin_st=1, with tag.
//    - Then IDLE; no new issue in the FIN cycle.
//  - Minimum latency: accept at cycle N, req at N+1, ack at N+1, broadcast at N+2.
//    Throughput is one op per 3 cycles at best.
//  - Byte enables:
//    - byte: be = 1<<addr[1:0]
//    - half: be = 3<<addr[1:0]
//    - word: be = 4'hF
//  - Store wdata = rs2 << (8*addr[1:0]).
//  - Load data: shift rdata right by 8*addr[1:0], then sign- or zero-extend from 8/16 bits.
//    A word load is passed through unchanged.
//  - Flush:
//    - In IDLE: no effect.
//    - In REQ: set killed; keep req asserted until ack (protocol must not be dropped).
//      The following FIN produces no exfin pulse.
//    - In FIN: suppress that cycle's pulse.
//    - Flush coincident with accept: the op is still accepted, then killed.
//  - A misaligned half/word access (see CONFIGURATION) is performed as computed.
//    Lanes that overflow bit 31 are dropped.
//  - Reset mid-op: immediate return to IDLE with outputs zeroed.
//    An outstanding memory req is abandoned; memory must also be reset.
// CONFIGURATION
//  LDST_MISALIGN_CHK_EN
//  - Defined:
//    - Adds output o_ex_misalign (1 bit); registered, valid with the exfin pulse, reset 0.
//    - Misaligned ops (half with addr[0]=1; word with addr[1:0]!=0) skip REQ.
//      They go IDLE->FIN directly with no memory access.
//    - The FIN pulse fires with o_ex_misalign=1; a load's result is 0.
//  - Undefined: port absent; misaligned ops behave as described in BEHAVIOUR.
// TESTING
//  1. Reset then idle: o_ready=1; req/exfin stay 0 for 10 cycles.
//  2. Word load: rs1=0x1000, imm=4, tag=5; ack next cycle with rdata=0xDEADBEEF.
//     Expect addr=0x1004, be=F, we=0; exfin_ld=1 one cycle later with tag 5 and res 0xDEADBEEF.
//  3. Signed byte load: addr=0x2003, rdata=0x80112233 -> res=0xFFFFFF80.
//     Same with i_unsigned=1 -> res=0x00000080.
//  4. Half store: addr=0x3002, rs2=0x0000ABCD, ack delayed 3 cycles.
//     Expect req held 4 cycles, be=4'b1100, wdata=0xABCD0000; then exfin_st with tag; no exfin_ld.
//  5. Flush in REQ during a load: req held until ack; no exfin_ld; o_ready=1 the cycle after FIN.
//  6. LDST_MISALIGN_CHK_EN: word load at 0x1001.
//     Expect no req; exfin_ld at accept+1 with misalign=1 and res=0.

Source files
------------

// File: rtl/exunit_ldst_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exunit_ldst_if : memory request/ack bus of the load/store unit.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface exunit_ldst_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/exunit_ldst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exunit_ldst : load/store execution unit (issue -> mem req/ack -> fin) |
// | Optional: LDST_MISALIGN_CHK_EN adds misalignment trapping.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module exunit_ldst #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  wire logic              clk,
  input  wire logic              rst,
  output logic                   o_ready,
  input  wire logic              i_issue_vld,
  input  wire logic [DATA_W-1:0] i_rs1_srcopr,
  input  wire logic [DATA_W-1:0] i_rs2_srcopr,
  input  wire logic [DATA_W-1:0] i_imm,
  input  wire logic              i_is_st,
  input  wire logic [1:0]        i_size,
  input  wire logic              i_unsigned,
  input  wire logic [TAG_W-1:0]  i_rrftag,
  input  wire logic              i_flush,
  exunit_ldst_if.master          mem,
  output logic                   o_exfin_ld,
  output logic [TAG_W-1:0]       o_ex_ld_rrftag,
  output logic [DATA_W-1:0]      o_exfin_ld_res,
  output logic                   o_exfin_st,
  output logic [TAG_W-1:0]       o_ex_st_rrftag
`ifdef LDST_MISALIGN_CHK_EN
  ,
  output logic                   o_ex_misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              killed_q, killed_d;
  logic              mis_q, mis_d;

  logic [DATA_W-1:0] w_ea;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic              w_misalign;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_res;
  logic              w_fin_ok;

  assign w_ea  = i_rs1_srcopr + i_imm;
  assign w_off = w_ea[1:0];

  // Upper lanes of a half access at offset 3 fall off the 4-bit enable.
  always_comb begin
    w_be = 4'hF;
    unique case (i_size)
      2'd0:    w_be = 4'b0001 << w_off;
      2'd1:    w_be = 4'b0011 << w_off;
      default: w_be = 4'hF;
    endcase
  end

`ifdef LDST_MISALIGN_CHK_EN
  assign w_misalign = ((i_size == 2'd1) && w_off[0]) ||
                      (i_size[1] && (w_off != 2'd0));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    be_d     = be_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    tag_d    = tag_q;
    killed_d = killed_q;
    mis_d    = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_issue_vld) begin
          addr_d   = w_ea;
          wdata_d  = i_rs2_srcopr << {w_off, 3'b000};
          rdata_d  = '0;
          be_d     = w_be;
          we_d     = i_is_st;
          size_d   = i_size;
          uns_d    = i_unsigned;
          tag_d    = i_rrftag;
          killed_d = i_flush;
          mis_d    = w_misalign;
          state_d  = w_misalign ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        // A killed op still completes the bus handshake.
        if (i_flush) killed_d = 1'b1;
        if (mem.ack) begin
          if (!we_q) rdata_d = mem.rdata;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      tag_q    <= '0;
      killed_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      tag_q    <= tag_d;
      killed_q <= killed_d;
      mis_q    <= mis_d;
    end
  end

  assign w_sh = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_res = w_sh;
    unique case (size_q)
      2'd0:    w_res = uns_q ? {{(DATA_W-8){1'b0}}, w_sh[7:0]}
                             : {{(DATA_W-8){w_sh[7]}}, w_sh[7:0]};
      2'd1:    w_res = uns_q ? {{(DATA_W-16){1'b0}}, w_sh[15:0]}
                             : {{(DATA_W-16){w_sh[15]}}, w_sh[15:0]};
      default: w_res = w_sh;
    endcase
    if (mis_q) w_res = '0;
  end

  assign o_ready   = (state_q == S_IDLE);
  assign mem.req   = (state_q == S_REQ);
  assign mem.we    = we_q;
  assign mem.addr  = {addr_q[DATA_W-1:2], 2'b00};
  assign mem.be    = be_q;
  assign mem.wdata = wdata_q;

  // Flush during FIN suppresses the pulse in that same cycle.
  assign w_fin_ok       = (state_q == S_FIN) && !killed_q && !i_flush;
  assign o_exfin_ld     = w_fin_ok && !we_q;
  assign o_exfin_st     = w_fin_ok && we_q;
  assign o_ex_ld_rrftag = tag_q;
  assign o_ex_st_rrftag = tag_q;
  assign o_exfin_ld_res = w_res;
`ifdef LDST_MISALIGN_CHK_EN
  assign o_ex_misalign  = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exunit_ldst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exunit_ldst : directed + randomized bench for exunit_ldst.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_exunit_ldst;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              o_ready, i_issue_vld, i_is_st, i_unsigned, i_flush;
  logic [31:0]       i_rs1_srcopr, i_rs2_srcopr, i_imm;
  logic [1:0]        i_size;
  logic [TAG_W-1:0]  i_rrftag;
  logic              o_exfin_ld, o_exfin_st;
  logic [TAG_W-1:0]  o_ex_ld_rrftag, o_ex_st_rrftag;
  logic [31:0]       o_exfin_ld_res;
`ifdef LDST_MISALIGN_CHK_EN
  logic              o_ex_misalign;
`endif

  exunit_ldst_if #(.DATA_W(DATA_W)) mem ();

  exunit_ldst #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .o_ready(o_ready), .i_issue_vld(i_issue_vld),
    .i_rs1_srcopr(i_rs1_srcopr), .i_rs2_srcopr(i_rs2_srcopr), .i_imm(i_imm),
    .i_is_st(i_is_st), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_rrftag(i_rrftag), .i_flush(i_flush), .mem(mem),
    .o_exfin_ld(o_exfin_ld), .o_ex_ld_rrftag(o_ex_ld_rrftag),
    .o_exfin_ld_res(o_exfin_ld_res), .o_exfin_st(o_exfin_st),
    .o_ex_st_rrftag(o_ex_st_rrftag)
`ifdef LDST_MISALIGN_CHK_EN
    , .o_ex_misalign(o_ex_misalign)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Observations gathered by do_op for one operation.
  int               obs_req, obs_ld, obs_st, obs_fin, obs_idle;
  logic             obs_ready0, obs_stable, obs_we, obs_mis;
  logic [31:0]      obs_addr, obs_wdata, obs_res;
  logic [3:0]       obs_be;
  logic [TAG_W-1:0] obs_tag;

  // Reference model from the architectural rules.
  function automatic logic [31:0] m_res(logic [31:0] rdata, logic [31:0] ea,
                                        logic [1:0] size, logic uns);
    logic [31:0] sh;
    longint v;
    sh = rdata >> (8 * ea[1:0]);
    if (size == 2'd0) begin
      v = sh & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = sh & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else v = sh;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(logic [31:0] ea, logic [1:0] size);
    int b;
    if (size == 2'd0) b = (1 << ea[1:0]) & 15;
    else if (size == 2'd1) b = (3 << ea[1:0]) & 15;
    else b = 15;
    return b[3:0];
  endfunction

  function automatic logic m_mis(logic [31:0] ea, logic [1:0] size);
`ifdef LDST_MISALIGN_CHK_EN
    return (size == 2'd1 && ea[0]) || (size >= 2'd2 && ea[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_op(input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic st, input logic [1:0] size,
                       input logic uns, input logic [TAG_W-1:0] tag,
                       input logic [31:0] rdata, input int ack_dly, input int flush_at);
    int c;
    obs_req = 0; obs_ld = 0; obs_st = 0; obs_fin = -1; obs_idle = -1;
    obs_stable = 1'b1; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
    obs_res = '0; obs_tag = '0; obs_mis = 1'b0;
    @(negedge clk);
    i_issue_vld = 1'b1; i_rs1_srcopr = rs1; i_rs2_srcopr = rs2; i_imm = imm;
    i_is_st = st; i_size = size; i_unsigned = uns; i_rrftag = tag;
    i_flush = (flush_at == 0); mem.ack = 1'b0;
    #1 obs_ready0 = o_ready;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      i_issue_vld = 1'b0;
      i_flush = (flush_at == c);
      mem.ack = 1'b0; mem.rdata = '0;
      if (mem.req) begin
        if (obs_req == 0) begin
          obs_addr = mem.addr; obs_be = mem.be; obs_wdata = mem.wdata; obs_we = mem.we;
        end else if (mem.addr !== obs_addr || mem.be !== obs_be || mem.wdata !== obs_wdata)
          obs_stable = 1'b0;
        if (obs_req == ack_dly) begin mem.ack = 1'b1; mem.rdata = rdata; end
        obs_req++;
      end
      #1;
      if (o_exfin_ld) begin
        obs_ld++; obs_fin = c; obs_tag = o_ex_ld_rrftag; obs_res = o_exfin_ld_res;
`ifdef LDST_MISALIGN_CHK_EN
        obs_mis = o_ex_misalign;
`endif
      end
      if (o_exfin_st) begin
        obs_st++; obs_fin = c; obs_tag = o_ex_st_rrftag;
`ifdef LDST_MISALIGN_CHK_EN
        obs_mis = o_ex_misalign;
`endif
      end
      if (o_ready || c >= 40) break;
    end
    obs_idle = c;
  endtask

  task automatic test_reset();
    i_issue_vld = 0; i_flush = 0; i_rs1_srcopr = 0; i_rs2_srcopr = 0; i_imm = 0;
    i_is_st = 0; i_size = 0; i_unsigned = 0; i_rrftag = 0; mem.ack = 0; mem.rdata = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_vec++; if ({mem.req, mem.we, mem.be, mem.addr, mem.wdata, o_exfin_ld, o_exfin_st} !== '0) begin
      n_err++; $display("FAIL reset_bus: req=%b we=%b be=%h addr=%h wdata=%h want all 0", mem.req, mem.we, mem.be, mem.addr, mem.wdata); end
    n_vec++; if ({o_ex_ld_rrftag, o_ex_st_rrftag, o_exfin_ld_res} !== '0) begin
      n_err++; $display("FAIL reset_fin_data: got %h/%h/%h want 0", o_ex_ld_rrftag, o_ex_st_rrftag, o_exfin_ld_res); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      n_vec++;
      if (o_ready !== 1'b1 || mem.req !== 1'b0 || o_exfin_ld !== 1'b0 || o_exfin_st !== 1'b0) begin
        n_err++; $display("FAIL idle_%0d: ready=%b req=%b ld=%b st=%b want 1/0/0/0", k, o_ready, mem.req, o_exfin_ld, o_exfin_st); end
    end
  endtask

  task automatic test_word_load();
    do_op(32'h1000, 32'h0, 32'h4, 1'b0, 2'd2, 1'b0, 6'd5, 32'hDEADBEEF, 0, -1);
    n_vec++; if (obs_ready0 !== 1'b1) begin n_err++; $display("FAIL wl_ready: got %b want 1", obs_ready0); end
    n_vec++; if (obs_addr !== 32'h1004 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      n_err++; $display("FAIL wl_req: addr=%h be=%h we=%b want 1004/f/0", obs_addr, obs_be, obs_we); end
    n_vec++; if (obs_req !== 1 || obs_fin !== 2) begin
      n_err++; $display("FAIL wl_latency: req_cycles=%0d fin=%0d want 1/2", obs_req, obs_fin); end
    n_vec++; if (obs_ld !== 1 || obs_st !== 0 || obs_tag !== 6'd5 || obs_res !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wl_fin: ld=%0d st=%0d tag=%0d res=%h want 1/0/5/deadbeef", obs_ld, obs_st, obs_tag, obs_res); end
    n_vec++; if (obs_idle !== 3) begin n_err++; $display("FAIL wl_ready_back: got %0d want 3", obs_idle); end
  endtask

  task automatic test_byte_load();
    do_op(32'h2000, 32'h0, 32'h3, 1'b0, 2'd0, 1'b0, 6'd11, 32'h80112233, 1, -1);
    n_vec++; if (obs_be !== 4'b1000 || obs_addr !== 32'h2000) begin
      n_err++; $display("FAIL bl_req: be=%h addr=%h want 8/2000", obs_be, obs_addr); end
    n_vec++; if (obs_ld !== 1 || obs_res !== 32'hFFFFFF80 || obs_tag !== 6'd11) begin
      n_err++; $display("FAIL bl_signed: ld=%0d res=%h tag=%0d want 1/ffffff80/11", obs_ld, obs_res, obs_tag); end
    do_op(32'h2000, 32'h0, 32'h3, 1'b0, 2'd0, 1'b1, 6'd12, 32'h80112233, 0, -1);
    n_vec++; if (obs_ld !== 1 || obs_res !== 32'h00000080) begin
      n_err++; $display("FAIL bl_unsigned: ld=%0d res=%h want 1/00000080", obs_ld, obs_res); end
  endtask

  task automatic test_half_store();
    do_op(32'h3000, 32'h0000ABCD, 32'h2, 1'b1, 2'd1, 1'b0, 6'd21, 32'h0, 3, -1);
    n_vec++; if (obs_req !== 4 || obs_stable !== 1'b1) begin
      n_err++; $display("FAIL hs_hold: req_cycles=%0d stable=%b want 4/1", obs_req, obs_stable); end
    n_vec++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD0000 || obs_we !== 1'b1 || obs_addr !== 32'h3000) begin
      n_err++; $display("FAIL hs_req: be=%h wdata=%h we=%b addr=%h want c/abcd0000/1/3000", obs_be, obs_wdata, obs_we, obs_addr); end
    n_vec++; if (obs_st !== 1 || obs_ld !== 0 || obs_tag !== 6'd21 || obs_fin !== 5) begin
      n_err++; $display("FAIL hs_fin: st=%0d ld=%0d tag=%0d fin=%0d want 1/0/21/5", obs_st, obs_ld, obs_tag, obs_fin); end
  endtask

  task automatic test_flush();
    do_op(32'h4000, 32'h0, 32'h8, 1'b0, 2'd2, 1'b0, 6'd30, 32'h12345678, 2, 2);
    n_vec++; if (obs_req !== 3 || obs_ld !== 0 || obs_idle !== 5) begin
      n_err++; $display("FAIL flush_req: req_cycles=%0d ld=%0d ready_back=%0d want 3/0/5", obs_req, obs_ld, obs_idle); end
    do_op(32'h4000, 32'h0, 32'h8, 1'b0, 2'd2, 1'b0, 6'd31, 32'h12345678, 0, 2);
    n_vec++; if (obs_ld !== 0 || obs_idle !== 3) begin
      n_err++; $display("FAIL flush_fin: ld=%0d ready_back=%0d want 0/3", obs_ld, obs_idle); end
    do_op(32'h4000, 32'h0, 32'h8, 1'b1, 2'd2, 1'b0, 6'd32, 32'h0, 1, 0);
    n_vec++; if (obs_req !== 2 || obs_st !== 0) begin
      n_err++; $display("FAIL flush_accept: req_cycles=%0d st=%0d want 2/0", obs_req, obs_st); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    i_issue_vld = 1; i_rs1_srcopr = 32'h5000; i_imm = 0; i_is_st = 0; i_size = 2'd2;
    i_unsigned = 0; i_rrftag = 6'd7; i_flush = 0; mem.ack = 0;
    @(negedge clk);
    i_rs1_srcopr = 32'h6000; i_rrftag = 6'd8;
    mem.ack = 1; mem.rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem.ack = 0; mem.rdata = 0;
    #1;
    n_vec++; if (o_ready !== 1'b0 || o_exfin_ld !== 1'b1 || o_ex_ld_rrftag !== 6'd7 || o_exfin_ld_res !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL b2b_fin: ready=%b ld=%b tag=%0d res=%h want 0/1/7/cafef00d", o_ready, o_exfin_ld, o_ex_ld_rrftag, o_exfin_ld_res); end
    @(negedge clk); #1;
    n_vec++; if (o_ready !== 1'b1 || mem.req !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: ready=%b req=%b want 1/0", o_ready, mem.req); end
    @(negedge clk);
    i_issue_vld = 0;
    #1;
    n_vec++; if (mem.req !== 1'b1 || mem.addr !== 32'h6000) begin
      n_err++; $display("FAIL b2b_second: req=%b addr=%h want 1/6000", mem.req, mem.addr); end
    mem.ack = 1; mem.rdata = 32'h0;
    @(negedge clk); mem.ack = 0;
    #1;
    n_vec++; if (o_exfin_ld !== 1'b1 || o_ex_ld_rrftag !== 6'd8) begin
      n_err++; $display("FAIL b2b_second_fin: ld=%b tag=%0d want 1/8", o_exfin_ld, o_ex_ld_rrftag); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    i_issue_vld = 1; i_rs1_srcopr = 32'h7000; i_rs2_srcopr = 32'h55; i_imm = 0;
    i_is_st = 1; i_size = 2'd0; i_rrftag = 6'd40; i_flush = 0; mem.ack = 0;
    @(negedge clk);
    i_issue_vld = 0;
    #1;
    n_vec++; if (mem.req !== 1'b1) begin n_err++; $display("FAIL rstmid_req: got %b want 1", mem.req); end
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    #1;
    n_vec++; if (o_ready !== 1'b1 || mem.req !== 1'b0 || mem.we !== 1'b0 || mem.wdata !== 32'h0 || o_exfin_st !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state: ready=%b req=%b we=%b wdata=%h st=%b want 1/0/0/0/0", o_ready, mem.req, mem.we, mem.wdata, o_exfin_st); end
  endtask

`ifdef LDST_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_op(32'h1000, 32'h0, 32'h1, 1'b0, 2'd2, 1'b0, 6'd9, 32'h12345678, 0, -1);
    n_vec++; if (obs_req !== 0 || obs_ld !== 1 || obs_fin !== 1 || obs_mis !== 1'b1 || obs_res !== 32'h0 || obs_tag !== 6'd9) begin
      n_err++; $display("FAIL misalign: req=%0d ld=%0d fin=%0d mis=%b res=%h tag=%0d want 0/1/1/1/0/9", obs_req, obs_ld, obs_fin, obs_mis, obs_res, obs_tag); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rs1, rs2, imm, rdata, ea, r;
    logic        st, uns, mis, killed;
    logic [1:0]  size;
    logic [5:0]  tag;
    int          dly, fl, exp_fin;
    for (int k = 0; k < 40; k++) begin
      rs1 = $urandom; rs2 = $urandom; rdata = $urandom; r = $urandom;
      imm = {{20{r[11]}}, r[11:0]};
      st = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); tag = 6'($urandom_range(0, 63));
      ea = rs1 + imm;
      if (size >= 2'd2) begin rs1 = rs1 - {30'b0, ea[1:0]}; ea = rs1 + imm; end
      dly = $urandom_range(0, 3);
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, dly + 3)) : -1;
      mis = m_mis(ea, size);
      exp_fin = mis ? 1 : dly + 2;
      killed = (fl >= 0 && fl <= exp_fin);
      do_op(rs1, rs2, imm, st, size, uns, tag, rdata, dly, fl);
      n_vec++; if (obs_req !== (mis ? 0 : dly + 1) || obs_idle !== exp_fin + 1 || obs_stable !== 1'b1) begin
        n_err++; $display("FAIL rnd%0d_timing: req=%0d idle=%0d stable=%b want %0d/%0d/1", k, obs_req, obs_idle, obs_stable, mis ? 0 : dly + 1, exp_fin + 1); end
      if (!mis) begin
        n_vec++; if (obs_addr !== {ea[31:2], 2'b00} || obs_be !== m_be(ea, size) || obs_we !== st) begin
          n_err++; $display("FAIL rnd%0d_req: addr=%h be=%h we=%b want %h/%h/%b", k, obs_addr, obs_be, obs_we, {ea[31:2], 2'b00}, m_be(ea, size), st); end
        if (st) begin
          n_vec++; if (obs_wdata !== (rs2 << (8 * ea[1:0]))) begin
            n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", k, obs_wdata, rs2 << (8 * ea[1:0])); end
        end
      end
      n_vec++; if (obs_ld !== ((!st && !killed) ? 1 : 0) || obs_st !== ((st && !killed) ? 1 : 0)) begin
        n_err++; $display("FAIL rnd%0d_pulse: ld=%0d st=%0d want %0d/%0d", k, obs_ld, obs_st, (!st && !killed) ? 1 : 0, (st && !killed) ? 1 : 0); end
      if (!killed) begin
        n_vec++; if (obs_tag !== tag || obs_fin !== exp_fin || obs_mis !== mis) begin
          n_err++; $display("FAIL rnd%0d_fin: tag=%0d fin=%0d mis=%b want %0d/%0d/%b", k, obs_tag, obs_fin, obs_mis, tag, exp_fin, mis); end
        if (!st) begin
          n_vec++; if (obs_res !== (mis ? 32'h0 : m_res(rdata, ea, size, uns))) begin
            n_err++; $display("FAIL rnd%0d_res: got %h want %h", k, obs_res, mis ? 32'h0 : m_res(rdata, ea, size, uns)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_flush();
    test_back_to_back();
`ifdef LDST_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
